// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC / fetch sequencer and the control unit.
// Holds the syscall opcodes and the sequencer state encoding.
package pc_fetch_sequencer_pkg;

    localparam logic [5:0] OP_SYSCALL_IN  = 6'b110011;
    localparam logic [5:0] OP_SYSCALL_OUT = 6'b110111;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_IN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// Next-PC selection: jump beats taken branch, and everything else falls through to pc+4.
// Purely combinational. Word-aligned targets keep the low two PC bits at zero.
module pc_fetch_sequencer_next_pc_mux #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic                  jump,
    input  logic                  branch,
    input  logic                  branch_cond,
    input  logic [25:0]           jump_index,
    input  logic [31:0]           branch_offset,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] branch_target;

    // The jump target stays within the 256 MB region that holds the delay-slot address.
    assign jump_target   = {pc_plus4[ADDR_WIDTH-1 -: 4], jump_index, 2'b00};
    assign branch_target = pc_plus4 + (branch_offset << 2);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && branch_cond) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer: next-PC selection, input-syscall stall
// with a button handshake, output-syscall display strobe, and retired count.
//
// state   | meaning
// RUN     | fetching normally; one instruction retires per cycle unless it is an input syscall
// WAIT_IN | core frozen on an input syscall until a fresh rising edge on input_confirm
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                   CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic                  jump,
    input  logic                  branch,
    input  logic                  branch_cond,
    input  logic [25:0]           jump_index,
    input  logic [31:0]           branch_offset,
    input  logic                  input_confirm,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  stall,
    output logic                  write_enable,
    output logic                  input_capture,
    output logic                  out_strobe,
    output logic [CNT_WIDTH-1:0]  retired
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic                  btn_prev;
    logic                  btn_edge;
    logic                  advance;
    logic                  take_target;
    logic [ADDR_WIDTH-1:0] next_pc;

    assign pc_plus4     = pc + PC_STEP;
    assign btn_edge     = input_confirm && !btn_prev;
    assign write_enable = !stall;

    pc_fetch_sequencer_next_pc_mux #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc_mux (
        .pc_plus4      (pc_plus4),
        .jump          (jump),
        .branch        (branch),
        .branch_cond   (branch_cond),
        .jump_index    (jump_index),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        input_capture = 1'b0;
        advance       = 1'b0;
        take_target   = 1'b0;
        case (state)
            RUN: begin
                if (op == OP_SYSCALL_IN) begin
                    stall      = 1'b1;
                    state_next = WAIT_IN;
                end else begin
                    advance     = 1'b1;
                    take_target = 1'b1;
                end
            end
            WAIT_IN: begin
                if (btn_edge) begin
                    // A coincident reset wins, so the register file must not latch.
                    input_capture = !reset;
                    advance       = 1'b1;
                    state_next    = RUN;
                end else begin
                    stall = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            retired    <= '0;
            btn_prev   <= 1'b1;
            out_strobe <= 1'b0;
        end else begin
            state      <= state_next;
            btn_prev   <= input_confirm;
            out_strobe <= (state == RUN) && (op == OP_SYSCALL_OUT);
            if (advance) begin
                pc      <= take_target ? next_pc : pc_plus4;
                retired <= retired + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a randomized
// run compared against an instruction-level reference model.
module tb_pc_fetch_sequencer;
    import pc_fetch_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        branch_cond = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic [31:0] branch_offset = 32'd0;
    logic        input_confirm = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        write_enable;
    logic        input_capture;
    logic        out_strobe;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    // reference model: architectural view of the sequencer
    logic [31:0] m_pc = 32'd0;
    bit          m_wait = 1'b0;
    logic [31:0] m_retired = 32'd0;
    bit          m_btn_prev = 1'b1;
    bit          m_strobe = 1'b0;

    pc_fetch_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .op            (op),
        .jump          (jump),
        .branch        (branch),
        .branch_cond   (branch_cond),
        .jump_index    (jump_index),
        .branch_offset (branch_offset),
        .input_confirm (input_confirm),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .write_enable  (write_enable),
        .input_capture (input_capture),
        .out_strobe    (out_strobe),
        .retired       (retired)
    );

    always #5 clock = ~clock;

    function automatic bit m_edge();
        return input_confirm && !m_btn_prev;
    endfunction

    function automatic bit m_stall();
        return (!m_wait && op == OP_SYSCALL_IN) || (m_wait && !m_edge());
    endfunction

    function automatic bit m_capture();
        return !reset && m_wait && m_edge();
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (jump) return (seq & 32'hF000_0000) | (32'(jump_index) * 32'd4);
        if (branch && branch_cond) return seq + branch_offset * 32'd4;
        return seq;
    endfunction

    always @(posedge clock) begin
        bit e;
        e = m_edge();
        if (reset) begin
            m_pc = 32'd0; m_wait = 1'b0; m_retired = 32'd0; m_btn_prev = 1'b1; m_strobe = 1'b0;
        end else begin
            m_strobe = 1'b0;
            if (!m_wait) begin
                if (op == OP_SYSCALL_IN) m_wait = 1'b1;
                else begin
                    m_strobe  = (op == OP_SYSCALL_OUT);
                    m_pc      = m_target();
                    m_retired = m_retired + 32'd1;
                end
            end else if (e) begin
                m_pc      = m_pc + 32'd4;
                m_retired = m_retired + 32'd1;
                m_wait    = 1'b0;
            end
            m_btn_prev = input_confirm;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [5:0] o, input logic j, input logic b, input logic c,
                          input logic [25:0] idx, input logic [31:0] off, input logic btn);
        op = o; jump = j; branch = b; branch_cond = c;
        jump_index = idx; branch_offset = off; input_confirm = btn;
    endtask

    task automatic do_reset(input logic btn);
        reset = 1'b1;
        set_in(6'd0, 0, 0, 0, 26'd0, 32'd0, btn);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(6'd0, 0, 0, 0, 26'd0, 32'd0, 1'b0);
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", out_strobe); end
        checks++; if (input_capture !== 1'b0) begin errors++; $display("FAIL reset_capture got %b want 0", input_capture); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc got %h want %h", pc, 32'(i * 4)); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL seq_stall got %b want 0", stall); end
            checks++; if (pc_plus4 !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_pc_plus4 got %h want %h", pc_plus4, 32'(i * 4 + 4)); end
            tick();
        end
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc_end got %h want %h", pc, 32'hC); end
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL seq_retired got %0d want 3", retired); end
    endtask

    task automatic test_branch();
        set_in(6'd0, 1, 0, 0, 26'd4, 32'd0, 1'b0);
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_setup_pc got %h want %h", pc, 32'h10); end
        set_in(6'd0, 0, 1, 1, 26'd0, 32'hFFFF_FFFE, 1'b0);
        tick();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL br_taken_pc got %h want %h", pc, 32'hC); end
        set_in(6'd0, 1, 0, 0, 26'd4, 32'd0, 1'b0);
        tick();
        set_in(6'd0, 0, 1, 0, 26'd0, 32'hFFFF_FFFE, 1'b0);
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL br_not_taken_pc got %h want %h", pc, 32'h14); end
    endtask

    task automatic test_jump();
        set_in(6'd0, 0, 1, 1, 26'd0, 32'h0FFF_FFFA, 1'b0);
        tick();
        checks++; if (pc !== 32'h4000_0000) begin errors++; $display("FAIL jmp_setup_pc got %h want %h", pc, 32'h4000_0000); end
        set_in(6'd0, 1, 1, 1, 26'h0000_040, 32'hFFFF_FFFE, 1'b0);
        tick();
        checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL jmp_priority_pc got %h want %h", pc, 32'h4000_0100); end
    endtask

    task automatic test_syscall_in();
        do_reset(1'b1);
        set_in(6'd0, 0, 0, 0, 26'd0, 32'd0, 1'b1);
        tick(); tick();
        set_in(OP_SYSCALL_IN, 1, 1, 1, 26'h3FF, 32'd8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sysin_stall[%0d] got %b want 1", i, stall); end
            checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL sysin_we[%0d] got %b want 0", i, write_enable); end
            checks++; if (input_capture !== 1'b0) begin errors++; $display("FAIL sysin_cap_held[%0d] got %b want 0", i, input_capture); end
            checks++; if (pc !== 32'h8) begin errors++; $display("FAIL sysin_pc_hold[%0d] got %h want %h", i, pc, 32'h8); end
            tick();
        end
        input_confirm = 1'b0;
        @(negedge clock);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sysin_stall_release got %b want 1", stall); end
        tick();
        input_confirm = 1'b1;
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sysin_edge_stall got %b want 0", stall); end
        checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL sysin_edge_we got %b want 1", write_enable); end
        checks++; if (input_capture !== 1'b1) begin errors++; $display("FAIL sysin_edge_cap got %b want 1", input_capture); end
        tick();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL sysin_next_pc got %h want %h", pc, 32'hC); end
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL sysin_retired got %0d want 3", retired); end
        set_in(6'd0, 0, 0, 0, 26'd0, 32'd0, 1'b1);
        @(negedge clock);
        checks++; if (input_capture !== 1'b0) begin errors++; $display("FAIL sysin_cap_after got %b want 0", input_capture); end
        tick();
    endtask

    task automatic test_syscall_out();
        do_reset(1'b0);
        tick();
        set_in(OP_SYSCALL_OUT, 0, 0, 0, 26'd0, 32'd0, 1'b0);
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sysout_stall got %b want 0", stall); end
        checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL sysout_early got %b want 0", out_strobe); end
        tick();
        checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL sysout_strobe got %b want 1", out_strobe); end
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL sysout_pc got %h want %h", pc, 32'h8); end
        set_in(6'd0, 0, 0, 0, 26'd0, 32'd0, 1'b0);
        tick();
        checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL sysout_one_cycle got %b want 0", out_strobe); end
    endtask

    task automatic test_reset_in_wait();
        do_reset(1'b0);
        tick();
        set_in(OP_SYSCALL_IN, 0, 0, 0, 26'd0, 32'd0, 1'b0);
        tick(); tick();
        reset = 1'b1;
        input_confirm = 1'b1;
        @(negedge clock);
        checks++; if (input_capture !== 1'b0) begin errors++; $display("FAIL rstwait_cap got %b want 0", input_capture); end
        tick();
        reset = 1'b0;
        op = 6'd0;
        @(negedge clock);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rstwait_pc got %h want %h", pc, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstwait_stall got %b want 0", stall); end
        checks++; if (input_capture !== 1'b0) begin errors++; $display("FAIL rstwait_cap_after got %b want 0", input_capture); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rstwait_retired got %0d want 0", retired); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset(1'b0);
        set_in(6'd0, 0, 1, 1, 26'd0, 32'hFFFF_FFFE, 1'b0);
        tick();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc got %h want %h", pc, 32'hFFFF_FFFC); end
        set_in(6'd0, 0, 0, 0, 26'd0, 32'd0, 1'b0);
        @(negedge clock);
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h want %h", pc_plus4, 32'h0); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", pc, 32'h0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: op = 6'd0;
                1: op = OP_SYSCALL_IN;
                2: op = OP_SYSCALL_OUT;
                default: op = 6'($urandom);
            endcase
            jump = ($urandom_range(0, 3) == 0);
            branch = $urandom_range(0, 1) == 1;
            branch_cond = $urandom_range(0, 1) == 1;
            jump_index = 26'($urandom);
            branch_offset = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            if ($urandom_range(0, 3) == 0) input_confirm = ~input_confirm;
            @(negedge clock);
            checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got %b want %b", i, stall, m_stall()); end
            checks++; if (write_enable !== !m_stall()) begin errors++; $display("FAIL rnd_we[%0d] got %b want %b", i, write_enable, !m_stall()); end
            checks++; if (input_capture !== m_capture()) begin errors++; $display("FAIL rnd_cap[%0d] got %b want %b", i, input_capture, m_capture()); end
            checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4[%0d] got %h want %h", i, pc_plus4, m_pc + 32'd4); end
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, m_pc); end
            checks++; if (retired !== m_retired) begin errors++; $display("FAIL rnd_retired[%0d] got %0d want %0d", i, retired, m_retired); end
            checks++; if (out_strobe !== m_strobe) begin errors++; $display("FAIL rnd_strobe[%0d] got %b want %b", i, out_strobe, m_strobe); end
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_syscall_in();
        test_syscall_out();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
